// File: rtl/circuit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : circuit_pkg
//  Description : Shared types and constants for the exhaustive vector checker.
//                GOLDEN_TT holds the reference truth table of the circuit
//                under test. Bit i is the expected output for input vector i.
//  Revision    : 1.0 - initial release
// ============================================================================
package circuit_pkg;

    localparam int VEC_W = 3;

    // Reference behaviour: out = in1 ^ in2 ^ in3
    localparam logic [7:0] GOLDEN_TT = 8'b1001_0110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage : circuit_pkg
`default_nettype wire

// File: rtl/circuit_golden.sv
`default_nettype none
// ============================================================================
//  Module      : circuit_golden
//  Description : Combinational golden model. Looks up the expected circuit
//                response for an input vector in GOLDEN_TT. Retarget the
//                checker to another 3-input circuit by changing that constant.
//  Ports       : vec      in  [VEC_W-1:0] applied input vector
//                expected out 1           reference output for vec
//  Revision    : 1.0 - initial release
// ============================================================================
module circuit_golden
    import circuit_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             expected
);

    assign expected = GOLDEN_TT[vec];

endmodule : circuit_golden
`default_nettype wire

// File: rtl/exhaustive_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : exhaustive_vector_checker
//  Description : Drives all eight input vectors to a 3-input combinational
//                circuit. Each vector is held for SETTLE_CYCLES cycles, then
//                the response is compared with the golden model in a single
//                CHECK cycle. The checker reports the mismatch count, the
//                first failing vector, a coverage bitmap and a pass flag.
//  Ports       : clk             in   clock, rising edge
//                rst_n           in   asynchronous reset, active low
//                start           in   run request, sampled in IDLE only
//                vec             out  applied vector (vec[2]=in1 .. vec[0]=in3)
//                dut_out         in   circuit response
//                busy            out  run in progress
//                done            out  one-cycle end-of-run pulse
//                pass            out  run result, valid from done onward
//                err_count       out  saturating mismatch counter
//                first_err_vec   out  vector of the first mismatch
//                first_err_valid out  first_err_vec holds a captured vector
//                cov             out  bit i set once vector i has been checked
//  Revision    : 1.0 - initial release
// ============================================================================
module exhaustive_vector_checker
    import circuit_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] vec,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_err_vec,
    output logic             first_err_valid,
    output logic [7:0]       cov
);

    localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       c_LAST_PASS   = 8'(PASSES - 1);
    localparam logic [ERR_W-1:0] c_ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] c_ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_next;
    logic [VEC_W-1:0]   r_vec;
    logic [3:0]         r_settle_cnt;
    logic [7:0]         r_pass_cnt;
    logic [ERR_W-1:0]   r_err;
    logic [VEC_W-1:0]   r_fev;
    logic               r_fvalid;
    logic [7:0]         r_cov;
    logic               r_pass;
    logic               r_busy;
    logic               r_done;

    logic               w_expected;
    logic               w_mismatch;
    logic               w_last_vec;
    logic               w_run_end;
    logic [ERR_W-1:0]   w_err_inc;
    logic [ERR_W-1:0]   w_err_next;
    logic [7:0]         w_cov_next;

    circuit_golden u_golden (
        .vec      (r_vec),
        .expected (w_expected)
    );

    // Case inequality so an X/Z response counts as a failure in 4-state sim.
    assign w_mismatch = (dut_out !== w_expected);
    assign w_last_vec = (r_vec == 3'd7);
    assign w_run_end  = w_last_vec && (r_pass_cnt == c_LAST_PASS);
    assign w_err_inc  = (r_err == c_ERR_MAX) ? r_err : (r_err + c_ERR_ONE);
    assign w_err_next = w_mismatch ? w_err_inc : r_err;
    assign w_cov_next = r_cov | (8'd1 << r_vec);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SETTLE;
            SETTLE:  if (r_settle_cnt == c_SETTLE_LAST) w_state_next = CHECK;
            CHECK:   w_state_next = w_run_end ? DONE : SETTLE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_pass_cnt   <= '0;
            r_err        <= '0;
            r_fev        <= '0;
            r_fvalid     <= 1'b0;
            r_cov        <= '0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // busy/done are registered from the next state so they line up
            // exactly with the state they describe.
            r_busy <= (w_state_next == SETTLE) || (w_state_next == CHECK);
            r_done <= (w_state_next == DONE);

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_settle_cnt <= '0;
                        r_pass_cnt   <= '0;
                        r_err        <= '0;
                        r_cov        <= '0;
                        r_fvalid     <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 4'd1;
                end
                CHECK: begin
                    r_settle_cnt <= '0;
                    r_cov        <= w_cov_next;
                    r_err        <= w_err_next;
                    if (w_mismatch && !r_fvalid) begin
                        r_fev    <= r_vec;
                        r_fvalid <= 1'b1;
                    end
                    if (w_run_end) begin
                        // Verdict uses this cycle's updates so it is ready
                        // in the DONE cycle itself.
                        r_pass <= (w_err_next == '0) && (w_cov_next == 8'hFF);
                    end else begin
                        r_vec <= r_vec + 3'd1;
                        if (w_last_vec) begin
                            r_pass_cnt <= r_pass_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign vec             = r_vec;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_vec   = r_fev;
    assign first_err_valid = r_fvalid;
    assign cov             = r_cov;

endmodule : exhaustive_vector_checker
`default_nettype wire

// File: tb/tb_exhaustive_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exhaustive_vector_checker
//  Description : Self-checking bench. A default checker instance sweeps a
//                set of behavioural circuits from a table; a second instance
//                (PASSES=3, ERR_W=3) watches a stuck-at-1 circuit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exhaustive_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start2;
    logic       dut_out;
    logic       dut_out2;
    logic       xval;
    int         mode;

    logic [2:0] vec,  vec2;
    logic       busy, busy2, done, done2, pass, pass2;
    logic [7:0] err_count;
    logic [2:0] err_count2;
    logic [2:0] fev,  fev2;
    logic       fvalid, fvalid2;
    logic [7:0] cov,  cov2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural circuit driven by the applied vector
    // 0: correct XOR  1: stuck-0  2: stuck-1  3: X on vec 6  4: inverted
    always_comb begin
        dut_out = ^vec;
        case (mode)
            1:       dut_out = 1'b0;
            2:       dut_out = 1'b1;
            3:       dut_out = (vec == 3'd6) ? xval : ^vec;
            4:       dut_out = ~^vec;
            default: dut_out = ^vec;
        endcase
    end

    assign dut_out2 = 1'b1;

    exhaustive_vector_checker u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vec             (vec),
        .dut_out         (dut_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_vec   (fev),
        .first_err_valid (fvalid),
        .cov             (cov)
    );

    exhaustive_vector_checker #(
        .SETTLE_CYCLES (2),
        .PASSES        (3),
        .ERR_W         (3)
    ) u_dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start2),
        .vec             (vec2),
        .dut_out         (dut_out2),
        .busy            (busy2),
        .done            (done2),
        .pass            (pass2),
        .err_count       (err_count2),
        .first_err_vec   (fev2),
        .first_err_valid (fvalid2),
        .cov             (cov2)
    );

    typedef struct {
        int         mode;
        logic [7:0] err;
        logic [2:0] fev;
        logic       fvalid;
        logic       pass;
        logic [7:0] cov;
    } row_t;

    row_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start, then follow the run until done (bounded). ncyc is the
    // number of edges after the accepting edge at which done was seen.
    task automatic run_default(input int repulse_at, output int ncyc, output bit vec_ok);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_at_T0", busy, 1);
        chk("vec_at_T0", vec, 0);
        chk("pass_clr_T0", pass, 0);
        ncyc   = 0;
        vec_ok = 1'b1;
        while (ncyc < 200) begin
            if (ncyc < 24 && vec !== 3'((ncyc / 3) % 8)) vec_ok = 1'b0;
            start = (ncyc == repulse_at);
            @(posedge clk);
            #1;
            ncyc++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int  ncyc;
        bit  vec_ok;
        bit  xm;
        bit  seen;
        string tag;

        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        xval   = 1'bx;
        // A simulator that collapses X picks a 2-state value; mismatch
        // expectations for the X row follow whatever value it holds.
        xm = (xval !== 1'b0);

        tbl[0] = '{0, 8'd0, 3'd0, 1'b0, 1'b1, 8'hFF};
        tbl[1] = '{1, 8'd4, 3'd1, 1'b1, 1'b0, 8'hFF};
        tbl[2] = '{2, 8'd4, 3'd0, 1'b1, 1'b0, 8'hFF};
        tbl[3] = '{3, xm ? 8'd1 : 8'd0, xm ? 3'd6 : 3'd0, xm, !xm, 8'hFF};
        tbl[4] = '{4, 8'd8, 3'd0, 1'b1, 1'b0, 8'hFF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fvalid", fvalid, 0);
        chk("rst_fev", fev, 0);
        chk("rst_cov", cov, 0);
        chk("rst_vec", vec, 0);
        chk("rst_busy2", busy2, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- table-driven sweeps ----------------
        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            tag  = $sformatf("row%0d", i);
            run_default(-1, ncyc, vec_ok);
            chk({tag, "_done_cycle"}, ncyc, 24);
            chk({tag, "_vec_seq"}, vec_ok, 1);
            chk({tag, "_busy_low"}, busy, 0);
            chk({tag, "_err"}, err_count, tbl[i].err);
            chk({tag, "_fev"}, fev, tbl[i].fev);
            chk({tag, "_fvalid"}, fvalid, tbl[i].fvalid);
            chk({tag, "_pass"}, pass, tbl[i].pass);
            chk({tag, "_cov"}, cov, tbl[i].cov);
            @(posedge clk);
            #1;
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_pass_hold"}, pass, tbl[i].pass);
        end

        // ---------------- start re-pulsed in SETTLE of vec 4 ----------------
        mode = 0;
        run_default(12, ncyc, vec_ok);
        chk("repulse_done_cycle", ncyc, 24);
        chk("repulse_vec_seq", vec_ok, 1);
        chk("repulse_pass", pass, 1);
        @(posedge clk);
        #1;
        chk("repulse_no_restart", busy, 0);

        // ---------------- reset during CHECK of vec 5 ----------------
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("midrun_vec", vec, 5);
        chk("midrun_err", err_count, 3);
        rst_n = 1'b0;
        #2;
        chk("arst_busy", busy, 0);
        chk("arst_vec", vec, 0);
        chk("arst_err", err_count, 0);
        chk("arst_cov", cov, 0);
        chk("arst_fvalid", fvalid, 0);
        chk("arst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("arst_no_done", seen, 0);
        mode = 0;
        run_default(-1, ncyc, vec_ok);
        chk("post_rst_done_cycle", ncyc, 24);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_cov", cov, 8'hFF);

        // ---------------- PASSES=3, ERR_W=3, stuck at 1 ----------------
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        chk("p3_busy_T0", busy2, 1);
        ncyc = 0;
        while (ncyc < 300) begin
            @(posedge clk);
            #1;
            ncyc++;
            if (done2) break;
        end
        chk("p3_done_cycle", ncyc, 72);
        chk("p3_err_sat", err_count2, 7);
        chk("p3_fev", fev2, 0);
        chk("p3_fvalid", fvalid2, 1);
        chk("p3_pass", pass2, 0);
        chk("p3_cov", cov2, 8'hFF);
        chk("p3_busy_low", busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_exhaustive_vector_checker
`default_nettype wire
